// File: rtl/uart_rx_frame_if.sv
// Serial line plus received-word handshake for uart_rx_frame.
// master = receiver side, slave = line driver / word consumer.
interface uart_rx_frame_if #(
    parameter int DBIT = 8
);
    logic            i_rx;
    logic            i_ready;
    logic [DBIT-1:0] o_data;
    logic            o_valid;
    logic            o_frame_err;
    logic            o_parity_err;
    logic            o_overrun;
    logic            o_busy;

    modport master (
        input  i_rx, i_ready,
        output o_data, o_valid, o_frame_err,
        output o_parity_err, o_overrun, o_busy
    );

    modport slave (
        output i_rx, i_ready,
        input  o_data, o_valid, o_frame_err,
        input  o_parity_err, o_overrun, o_busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver with one-entry holding register.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16,
    parameter int DVSR    = 5,
    parameter int DVSR_W  = 8
) (
    input  logic      i_clk,
    input  logic      i_reset,
    uart_rx_frame_if.master bus
);
    localparam int SMAX = (SB_TICK > OVS) ? SB_TICK : OVS;
    localparam int S_W  = $clog2(SMAX);

    localparam logic [DVSR_W-1:0] DIV_LAST  = DVSR_W'(DVSR - 1);
    localparam logic [S_W-1:0]    S_HALF    = S_W'(OVS / 2 - 1);
    localparam logic [S_W-1:0]    S_BIT     = S_W'(OVS - 1);
    localparam logic [S_W-1:0]    S_STOP    = S_W'(SB_TICK - 1);
    localparam logic [3:0]        N_LAST    = 4'(DBIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP_ST
    } state_e;

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    logic [DVSR_W-1:0] div_q, div_d;
    logic              tick;
    state_e            state_q, state_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [3:0]        n_q, n_d;
    logic [DBIT-1:0]   sr_q, sr_d;
    logic              perr_q, perr_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              busy;

    logic [DBIT-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic              fe_q, fe_d;
    logic              pe_q, pe_d;
    logic              ovr_q, ovr_d;

    assign tick = (div_q == DIV_LAST);

    // State register, synchronizer and all datapath flops
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            state_q   <= S_IDLE;
            s_q       <= '0;
            n_q       <= '0;
            sr_q      <= '0;
            perr_q    <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= bus.i_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            div_q     <= div_d;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            sr_q      <= sr_d;
            perr_q    <= perr_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next state: a start needs a falling edge so a held-low break stays idle
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sr_d    = sr_q;
        perr_d  = perr_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    s_d     = '0;
                    div_d   = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_q == S_HALF) begin
                        s_d = '0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            n_d     = '0;
                            perr_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        s_d  = '0;
                        sr_d = {rx_s_q, sr_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP_ST;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        perr_d  = ^{sr_q, rx_s_q};
                        state_d = S_STOP_ST;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP_ST: begin
                if (tick) begin
                    if (s_q == S_STOP) begin
                        s_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and the stop-sample strobe with its framing result
    always_comb begin
        busy   = (state_q != S_IDLE);
        done_d = (state_q == S_STOP_ST) && tick && (s_q == S_STOP);
        ferr_d = done_d ? ~rx_s_q : ferr_q;
    end

    // Holding register: load completed frame if empty or draining, else overrun
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        ovr_d   = ovr_q;
        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end
        if (done_q) begin
            if (!valid_q || bus.i_ready) begin
                data_d  = sr_q;
                fe_d    = ferr_q;
                pe_d    = perr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frame_err = fe_q;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = pe_q;
`else
    assign bus.o_parity_err = 1'b0;
`endif
    assign bus.o_overrun   = ovr_q;
    assign bus.o_busy      = busy;
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver with an oversampling baud generator, configurable data width and stop bits, and a one-entry output holding register with a valid/ready handshake.
It delivers each received byte or word together with per-frame error flags: framing, parity and overrun.
It sits between the pad-side rx line and the operand/opcode interface FSM that feeds the ALU.
Default timing is 80 clk per bit: DVSR=5, OVS=16.

Parameters:
DBIT, 8, data bits per frame (5..9), LSB first
SB_TICK, 16, stop-bit length in oversample ticks (16 = 1 stop, 24 = 1.5, 32 = 2)
OVS, 16, oversample ticks per bit (even, >=4)
DVSR, 5, clk cycles per oversample tick
DVSR_W, 8, width of the divisor counter; must hold DVSR-1

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  reset, synchronous, active-high
i_rx  in  1  asynchronous serial input, idle high
i_ready  in  1  consumer accepts o_data when o_valid=1
o_data  out  DBIT  received data word
o_valid  out  1  holding register full
o_frame_err  out  1  stop bit sampled low, for the word in the holding register
o_parity_err  out  1  parity mismatch, for the word in the holding register (0 if PARITY_EN is undefined)
o_overrun  out  1  sticky; a completed frame was dropped because the holding register was full
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: the following are all cleared at the next clk edge; the synchronizer flops are set to 1.
  - outputs: o_data=0, o_valid=0, o_frame_err=0, o_parity_err=0, o_overrun=0, o_busy=0
  - FSM=IDLE, all counters 0
- Reset mid-frame aborts the frame with no output.
- Input path: i_rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- Tick generator:
  - Free-running counter 0..DVSR-1.
  - tick=1 for one clk when the counter equals DVSR-1.
  - The counter is cleared on the IDLE->START transition, so sampling is aligned to the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 -> START, with the tick counter cleared.
  - START: at OVS/2 ticks, if rx_s==0 -> DATA with the sample counter at 0. If rx_s==1, it is a glitch -> IDLE with no output.
  - DATA: every OVS ticks, shift rx_s into the MSB of the shift register (LSB first on the wire). After DBIT samples -> PARITY if PARITY_EN is defined, else -> STOP.
  - PARITY: after OVS ticks, sample the parity bit and compute the mismatch -> STOP.
  - STOP: after SB_TICK ticks, sample rx_s; frame_err = ~rx_s -> IDLE, and the frame completes.
- Frame complete: on the clk after the stop sample tick.
  - If o_valid==0, or o_valid&&i_ready in the same cycle: load o_data and the error flags, and set o_valid=1.
  - Otherwise the frame is dropped, the held word is retained and o_overrun is set to 1.
- Handshake:
  - o_valid&&i_ready clears o_valid on the next edge, unless a new frame loads in the same cycle (o_valid stays 1 with the new data).
  - o_data and the error flags are stable while o_valid=1.
- o_overrun clears only on reset.
- A frame-error frame is still delivered. The FSM returns to IDLE and waits for rx_s high-to-low, so a line held low (break) produces no further frames.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: one parity bit follows the data bits, expected even parity (XOR of data bits and parity bit == 0). A mismatch sets o_parity_err with the word. The frame is one bit longer.
- Undefined: the PARITY state and checker are absent, o_parity_err is tied to 0, and the frame is start + DBIT + stop.

Test Plan:
- Defaults, 80 clk/bit, frames 0x01, 0x02, 0x20 back-to-back with i_ready=1 -> three o_valid pulses, o_data=0x01, 0x02, 0x20, no error flags.
- Stop bit driven 0 for frame 0xA5 -> o_data=0xA5 with o_frame_err=1. Next good frame 0x3C -> o_frame_err=0.
- i_rx low pulse of 20 clk while idle -> no o_valid, o_busy returns to 0 within 45 clk of the pulse start.
- i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11, o_overrun=1. Raise i_ready -> 0x11 accepted, o_valid=0.
- UART_RX_PARITY_EN defined, frame 0x07 with parity bit 1 -> o_parity_err=0; with parity bit 0 -> o_parity_err=1.
- Assert i_reset during data bit 4 of 0xFF -> all outputs 0 next clk, no o_valid. A following frame 0x55 is received correctly.
